// File: rtl/fb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_sram_arbiter
// Function : Shares one async framebuffer SRAM between scan-out reads and
//            capture writes; read priority with a write starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module fb_sram_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 18,
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_i,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int CW = $clog2(RD_LAT + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [CW-1:0] RD_LAST    = CW'(RD_LAT);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD        = 3'd1,
      ST_WR_SETUP  = 3'd2,
      ST_WR_STROBE = 3'd3,
      ST_WR_HOLD   = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            rd_grant;
   logic            wr_grant;
   logic            rd_done;
   logic [SW-1:0]   starve_cnt;
   logic [CW-1:0]   rd_cnt;

   // Write wins a contested IDLE slot only once it has lost STARVE_MAX times.
   always_comb begin
      state_nxt = state;
      rd_grant  = 1'b0;
      wr_grant  = 1'b0;
      rd_done   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (wr_req && (!rd_req || (starve_cnt == STARVE_LIM))) begin
               wr_grant  = 1'b1;
               state_nxt = ST_WR_SETUP;
            end else if (rd_req) begin
               rd_grant  = 1'b1;
               state_nxt = ST_RD;
            end
         end
         ST_RD: begin
            if (rd_cnt == RD_LAST) begin
               rd_done   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_WR_SETUP:  state_nxt = ST_WR_STROBE;
         ST_WR_STROBE: state_nxt = ST_WR_HOLD;
         ST_WR_HOLD:   state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         rd_cnt     <= '0;
      end else begin
         if (wr_grant) begin
            starve_cnt <= '0;
         end else if (rd_grant && wr_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
         if (rd_grant) begin
            rd_cnt <= CW'(1);
         end else if ((state == ST_RD) && !rd_done) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
      end
   end

   // Strobes are registered from the next state so every SRAM pin is glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_dq_oe <= 1'b0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         rd_ack     <= 1'b0;
         wr_ack     <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
      end else begin
         sram_ce_n  <= (state_nxt == ST_IDLE);
         sram_oe_n  <= (state_nxt != ST_RD);
         sram_we_n  <= (state_nxt != ST_WR_STROBE);
         sram_dq_oe <= (state_nxt == ST_WR_SETUP) || (state_nxt == ST_WR_STROBE) ||
                       (state_nxt == ST_WR_HOLD);
         rd_ack     <= rd_grant;
         wr_ack     <= wr_grant;
         rd_valid   <= rd_done;
         if (rd_grant) begin
            sram_addr <= rd_addr;
         end else if (wr_grant) begin
            sram_addr <= wr_addr;
            sram_dq_o <= wr_data;
         end
         if (rd_done) begin
            rd_data <= sram_dq_i;
         end
      end
   end

endmodule
`default_nettype wire
